bscan_spi_seq: RTL



---
 rtl/bscan_spi_pkg.sv | 20 ++
 rtl/bscan_spi_bitcnt.sv | 35 +++
 rtl/bscan_spi_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bscan_spi_pkg.sv
// Shared definitions for the BSCAN SPI loader sequencer.
package bscan_spi_pkg;

    // Width of the command header shifted in on TDI: 32-bit tag plus 16-bit length.
    localparam int HDR_BITS = 48;

    // Tag the host must place in the upper header bits for a transfer to run.
    localparam logic [31:0] DEFAULT_MAGIC = 32'h59A6_59A6;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/bscan_spi_bitcnt.sv
// Loadable down-counter shared by the header, flash transfer and drain phases.
// The counter holds the number of shift cycles still to come in the current
// phase; tc flags the cycle on which the last one is being consumed.
module bscan_spi_bitcnt #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count;

    // Count register: clear beats load, load beats decrement, never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign tc = (count == ONE);

endmodule

// File: rtl/bscan_spi_seq.sv
// JTAG-to-SPI transfer sequencer: parses the command header from TDI, holds
// flash chip-select low for exactly LEN shift cycles while MISO is written into
// the capture RAM, then replays the captured bits on TDO1.
module bscan_spi_seq
    import bscan_spi_pkg::*;
#(
    parameter logic [31:0] MAGIC  = DEFAULT_MAGIC,
    parameter int          ADDR_W = 14,
    parameter int          LEN_W  = 16
) (
    input  logic              DRCK1,
    input  logic              RESET_N,
    input  logic              TAP_RESET,
    input  logic              SEL1,
    input  logic              SHIFT,
    input  logic              CAPTURE,
    input  logic              UPDATE,
    input  logic              TDI,
    input  logic              MISO,
    input  logic              RAM_DO,
    output logic              CSB,
    output logic              RAM_WE,
    output logic              RAM_DI,
    output logic [ADDR_W-1:0] RAM_WADDR,
    output logic [ADDR_W-1:0] RAM_RADDR,
    output logic              TDO1,
    output logic              BUSY,
    output logic              ERR
);

    localparam int                CNT_W    = LEN_W + 1;
    localparam logic [CNT_W-1:0]  MAX_LEN  = CNT_W'(1) << ADDR_W;
    localparam logic [CNT_W-1:0]  HDR_LOAD = CNT_W'(HDR_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_next;

    logic                shift;
    logic                abort;

    logic [HDR_BITS-1:0] hdr;
    logic [HDR_BITS-1:0] hdr_next;
    logic [31:0]         hdr_tag;
    logic [LEN_W-1:0]    hdr_len;
    logic [CNT_W-1:0]    hdr_len_ext;
    logic [CNT_W-1:0]    xfer_len;
    logic                tag_ok;
    logic                len_ok;
    logic                len_nonzero;
    logic                hdr_go;

    logic                csb;
    logic [ADDR_W-1:0]   waddr;
    logic [ADDR_W-1:0]   raddr;

    logic                cnt_clear;
    logic                cnt_load;
    logic                cnt_dec;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_tc;

    assign shift = SEL1 & SHIFT;
    assign abort = UPDATE | CAPTURE | TAP_RESET;

    // The decode on the 48th header bit looks at the header as it will be
    // after this shift, so the incoming TDI bit is folded in here.
    assign hdr_next    = {TDI, hdr[HDR_BITS-1:1]};
    assign hdr_tag     = hdr_next[HDR_BITS-1 -: 32];
    assign hdr_len     = hdr_next[LEN_W-1:0];
    assign hdr_len_ext = {1'b0, hdr_len};
    assign xfer_len    = {1'b0, hdr[LEN_W-1:0]};
    assign tag_ok      = (hdr_tag == MAGIC);
    assign len_ok      = (hdr_len_ext <= MAX_LEN);
    assign len_nonzero = |hdr_len;
    assign hdr_go      = tag_ok & len_ok & len_nonzero;

    // One counter serves every phase; it is reloaded at each phase boundary.
    bscan_spi_bitcnt #(
        .W (CNT_W)
    ) u_bitcnt (
        .clk      (DRCK1),
        .rst_n    (RESET_N),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    // State register.
    always_ff @(posedge DRCK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; an abort request overrides whatever the shift would do.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (shift) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (shift && cnt_tc) begin
                    if (!tag_ok || !len_ok) begin
                        state_next = ST_ERR;
                    end else if (!len_nonzero) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (shift && cnt_tc) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (shift && cnt_tc) begin
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = state;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
        end
    end

    // Counter control: load the remaining-cycle count on phase entry, step it on shifts.
    always_comb begin
        cnt_clear = abort;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        if (!abort && shift) begin
            case (state)
                ST_IDLE: begin
                    cnt_load = 1'b1;
                    cnt_val  = HDR_LOAD;
                end
                ST_HDR: begin
                    if (cnt_tc) begin
                        cnt_load = 1'b1;
                        cnt_val  = hdr_len_ext;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_XFER: begin
                    if (cnt_tc) begin
                        cnt_load = 1'b1;
                        cnt_val  = xfer_len;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    cnt_dec = 1'b1;
                end
                default: begin
                    cnt_dec = 1'b0;
                end
            endcase
        end
    end

    // Header shift register, chip-select and RAM address pointers.
    always_ff @(posedge DRCK1 or negedge RESET_N) begin
        if (!RESET_N) begin
            hdr   <= '0;
            csb   <= 1'b1;
            waddr <= '0;
            raddr <= '0;
        end else if (abort) begin
            csb   <= 1'b1;
            waddr <= '0;
            raddr <= '0;
        end else if (shift) begin
            case (state)
                ST_IDLE: begin
                    hdr <= hdr_next;
                end
                ST_HDR: begin
                    hdr <= hdr_next;
                    if (cnt_tc && hdr_go) begin
                        csb   <= 1'b0;
                        waddr <= '0;
                    end
                end
                ST_XFER: begin
                    waddr <= waddr + ADDR_ONE;
                    if (cnt_tc) begin
                        csb   <= 1'b1;
                        raddr <= '0;
                    end
                end
                ST_DRAIN: begin
                    raddr <= raddr + ADDR_ONE;
                end
                default: begin
                    hdr <= hdr;
                end
            endcase
        end
    end

    // Output decode. The RAM write is not gated by abort so that a bit
    // shifted on an aborting edge still lands in the RAM.
    assign CSB       = csb;
    assign RAM_WE    = (state == ST_XFER) & SEL1 & SHIFT;
    assign RAM_DI    = MISO;
    assign RAM_WADDR = waddr;
    assign RAM_RADDR = raddr;
    assign TDO1      = (state == ST_DRAIN) ? RAM_DO : 1'b0;
    assign BUSY      = (state == ST_HDR) | (state == ST_XFER) | (state == ST_DRAIN);
    assign ERR       = (state == ST_ERR);

endmodule
